uart_rx: RTL and testbench

- Serial UART receiver paired with the existing transmitter. Frame format: 8 data bits LSB first, 1 start bit, 1 stop bit, no parity by default.
- Oversamples the asynchronous `rx` line on the system clock and samples each bit at mid-period.
- Presents each received byte with a one-cycle `data_valid` strobe to the sensor command/response logic on the FPGA.

---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop rx synchronizer, mid-bit sampling, one-cycle strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int COUNTER_WIDTH  = $clog2(CLOCKS_PER_BIT)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] received_data,
    output logic       data_valid,
    output logic       is_receiving,
    output logic       framing_error,
    output logic       parity_error,
    output logic [2:0] debug_state
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        CLEANUP    = 3'd5
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] HALF_TICK = COUNTER_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [COUNTER_WIDTH-1:0] LAST_TICK = COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);

    state_t                   state, state_next;
    logic                     rx_meta, rx_sync;
    logic [COUNTER_WIDTH-1:0] counter, counter_next;
    logic [2:0]               index, index_next;
    logic [7:0]               shift_reg, shift_reg_next;
    logic [7:0]               received_data_next;
    logic                     data_valid_next, framing_error_next, parity_error_next;
    logic                     is_receiving_next;
    logic                     parity_bad;

`ifdef UART_RX_PARITY_EN
    logic parity_bit, parity_bit_next;
    assign parity_bad = parity_bit != (^shift_reg);
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            state         <= IDLE;
            counter       <= '0;
            index         <= '0;
            shift_reg     <= '0;
            received_data <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            is_receiving  <= 1'b0;
            debug_state   <= IDLE;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            rx_meta       <= rx;
            rx_sync       <= rx_meta;
            state         <= state_next;
            counter       <= counter_next;
            index         <= index_next;
            shift_reg     <= shift_reg_next;
            received_data <= received_data_next;
            data_valid    <= data_valid_next;
            framing_error <= framing_error_next;
            parity_error  <= parity_error_next;
            is_receiving  <= is_receiving_next;
            debug_state   <= state;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= parity_bit_next;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
        state_next         = state;
        counter_next       = counter;
        index_next         = index;
        shift_reg_next     = shift_reg;
        received_data_next = received_data;
        is_receiving_next  = is_receiving;
        data_valid_next    = 1'b0;
        framing_error_next = 1'b0;
        parity_error_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next    = parity_bit;
`endif
        case (state)
            IDLE: begin
                counter_next      = '0;
                index_next        = '0;
                is_receiving_next = 1'b0;
                if (!rx_sync) begin
                    state_next        = START_BIT;
                    is_receiving_next = 1'b1;
                end
            end
            START_BIT: begin
                if (counter == HALF_TICK) begin
                    counter_next = '0;
                    if (!rx_sync) begin
                        state_next = DATA_BITS;
                    end else begin
                        // Start bit gone by mid-bit: a glitch, drop it silently.
                        state_next        = IDLE;
                        is_receiving_next = 1'b0;
                    end
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            DATA_BITS: begin
                if (counter == LAST_TICK) begin
                    counter_next              = '0;
                    shift_reg_next[index]     = rx_sync;
                    if (index == 3'd7) begin
                        index_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY_BIT;
`else
                        state_next = STOP_BIT;
`endif
                    end else begin
                        index_next = index + 1'b1;
                    end
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (counter == LAST_TICK) begin
                    counter_next    = '0;
                    parity_bit_next = rx_sync;
                    state_next      = STOP_BIT;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
`endif
            STOP_BIT: begin
                if (counter == LAST_TICK) begin
                    counter_next       = '0;
                    is_receiving_next  = 1'b0;
                    state_next         = CLEANUP;
                    framing_error_next = !rx_sync;
                    parity_error_next  = parity_bad;
                    if (rx_sync && !parity_bad) begin
                        received_data_next = shift_reg;
                        data_valid_next    = 1'b1;
                    end
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            CLEANUP: begin
                // Hold here through a break so a stuck-low line cannot start a frame.
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames checked
// against a frame-level expectation queue (byte, stop/parity outcome, deadline).
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN    = 1;
    localparam int A5_LAT    = 171;
`else
    localparam int PAR_EN    = 0;
    localparam int A5_LAT    = 155;
`endif
    // Start edge to strobe: (frame bits - 0.5) bit periods plus synchronizer/register delay.
    localparam int LAT = ((19 + 2 * PAR_EN) * CPB) / 2 + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] received_data;
    logic       data_valid;
    logic       is_receiving;
    logic       framing_error;
    logic       parity_error;
    logic [2:0] debug_state;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .received_data (received_data),
        .data_valid    (data_valid),
        .is_receiving  (is_receiving),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .debug_state   (debug_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         valid;
        bit         ferr;
        bit         perr;
        int         start_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seen_data[$];
    logic [7:0] model_data;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         last_start_cyc = 0;
    int         last_valid_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Compare process: every strobe must match the oldest pending frame within the latency window.
    always @(negedge clock) begin : compare
        exp_t e;
        int   d;
        if (reset) begin
            exp_q.delete();
            model_data = 8'h00;
        end else begin
            if (data_valid || framing_error || parity_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, data_valid, framing_error, parity_error}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    d = cyc - e.start_cyc;
                    check("strobe_latency_in_window", 32'(d >= LAT - 1 && d <= LAT + 1), 32'd1);
                    check("data_valid", 32'(data_valid), 32'(e.valid));
                    check("framing_error", 32'(framing_error), 32'(e.ferr));
                    check("parity_error", 32'(parity_error), 32'(e.perr));
                    if (e.valid) model_data = e.data;
                end
                check("valid_ferr_exclusive", 32'(data_valid & framing_error), 32'd0);
                check("is_receiving_low_at_strobe", 32'(is_receiving), 32'd0);
                if (data_valid) begin
                    seen_data.push_back(received_data);
                    last_valid_cyc = cyc;
                end
                if (framing_error) n_ferr++;
                if (parity_error) n_perr++;
            end else if (exp_q.size() > 0 && cyc > exp_q[0].start_cyc + LAT + 1) begin
                check("strobe_by_deadline", 32'(data_valid | framing_error | parity_error), 32'd1);
                void'(exp_q.pop_front());
            end
            check("received_data_hold", 32'(received_data), 32'(model_data));
        end
    end

    task automatic bit_time(input logic b);
        rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    // Drives one frame; the expectation is queued as the stop bit begins, so an aborted frame queues nothing.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        exp_t e;
        last_start_cyc = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(data[i]);
        if (PAR_EN != 0) bit_time(par);
        e.data      = data;
        e.perr      = (PAR_EN != 0) && (par != (^data));
        e.ferr      = !stop;
        e.valid     = stop && !e.perr;
        e.start_cyc = last_start_cyc;
        exp_q.push_back(e);
        bit_time(stop);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] d;
        logic       stop;
        logic       par;
        logic       saw;
        int         n0;
        int         f0;
        int         gap;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", {18'd0, received_data, data_valid, is_receiving,
                                framing_error, parity_error, debug_state}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_outputs", {18'd0, received_data, data_valid, is_receiving,
                                   framing_error, parity_error, debug_state}, 32'd0);
        end

        send_frame(8'hA5, 1'b1, ^8'hA5);
        check("a5_data", 32'(received_data), 32'h0000_00A5);
        check("a5_latency_in_window", 32'(last_valid_cyc - last_start_cyc >= A5_LAT - 1 &&
                                          last_valid_cyc - last_start_cyc <= A5_LAT + 1), 32'd1);

        n0 = seen_data.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clock);
        check("b2b_count", 32'(seen_data.size() - n0), 32'd3);
        if (seen_data.size() >= n0 + 3) begin
            check("b2b_byte0", 32'(seen_data[n0]), 32'h00);
            check("b2b_byte1", 32'(seen_data[n0 + 1]), 32'hFF);
            check("b2b_byte2", 32'(seen_data[n0 + 2]), 32'h3C);
        end

        f0 = n_ferr;
        n0 = seen_data.size();
        send_frame(8'h5A, 1'b0, ^8'h5A);
        rx = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            check("break_holds_cleanup", 32'(debug_state), 32'd5);
        end
        check("ferr_keeps_data", 32'(received_data), 32'h3C);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        check("break_released_idle", 32'(debug_state), 32'd0);
        check("break_ferr_pulses", 32'(n_ferr - f0), 32'd1);
        check("break_no_valid", 32'(seen_data.size() - n0), 32'd0);

        saw = 1'b0;
        rx  = 1'b0;
        repeat (5) @(negedge clock);
        rx = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            saw = saw | is_receiving;
        end
        check("glitch_saw_receiving", 32'(saw), 32'd1);
        check("glitch_back_idle", {29'd0, debug_state}, 32'd0);
        check("glitch_not_receiving", 32'(is_receiving), 32'd0);

        d = 8'h96;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(d[i]);
        rx = d[4];
        repeat (CPB / 2) @(negedge clock);
        check("mid_frame_receiving", 32'(is_receiving), 32'd1);
        rx    = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs", {18'd0, received_data, data_valid, is_receiving,
                                framing_error, parity_error, debug_state}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        send_frame(8'h81, 1'b1, ^8'h81);
        check("post_abort_data", 32'(received_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        f0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1);
        check("parity_good_data", 32'(received_data), 32'h07);
        send_frame(8'h81, 1'b1, 1'b1);
        check("parity_bad_keeps_data", 32'(received_data), 32'h07);
        check("parity_bad_pulses", 32'(n_perr - f0), 32'd1);
`endif

        for (int k = 0; k < 40; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = 1'($urandom_range(0, 1));
            send_frame(d, stop, par);
            if (stop) gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 20));
            else      gap = int'($urandom_range(6, 20));
            rx = 1'b1;
            repeat (gap) @(negedge clock);
        end

        rx = 1'b1;
        repeat (LAT + 10) @(negedge clock);
        check("all_frames_accounted", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
